// File: rtl/matrix_stream_source_if.sv
// Stream bundle between matrix_stream_source and the matrix multiplier input port.
// The master drives data/valid/last; the slave drives ready.
interface matrix_stream_source_if;
  logic [31:0] input_r_TDATA_0;
  logic        input_r_TVALID_0;
  logic        input_r_TLAST_0;
  logic        input_r_TREADY_0;

  modport master (
    output input_r_TDATA_0, input_r_TVALID_0, input_r_TLAST_0,
    input  input_r_TREADY_0
  );

  modport slave (
    input  input_r_TDATA_0, input_r_TVALID_0, input_r_TLAST_0,
    output input_r_TREADY_0
  );
endinterface

// File: rtl/matrix_stream_source.sv
// AXI-Stream source: after a hold-off, emits frames of matrix A then B filled with FILL_VALUE.
// Optional MATRIX_SRC_ERR_INJECT_EN adds inject_error to corrupt word 0 of one later frame.
module matrix_stream_source #(
  parameter int unsigned MATRIX_DIM        = 3,
  parameter logic [31:0] FILL_VALUE        = 32'd2,
  parameter logic [19:0] Start_Delay_Value = 20'd20000,
  parameter logic [7:0]  Frame_Gap         = 8'd16,
  parameter logic [7:0]  Num_Frames        = 8'd1
) (
  input  logic                          clk,
  input  logic                          reset,
`ifdef MATRIX_SRC_ERR_INJECT_EN
  input  logic                          inject_error,
`endif
  matrix_stream_source_if.master        axis,
  output logic [7:0]                    Frame_Counter,
  output logic                          Busy
);

  localparam int unsigned   FrameLen  = 2 * MATRIX_DIM * MATRIX_DIM;
  localparam int unsigned   IdxW      = (FrameLen > 1) ? $clog2(FrameLen) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameLen - 1);
  localparam logic [19:0]   DelayLast = Start_Delay_Value - 20'd1;
  localparam logic [7:0]    GapLast   = Frame_Gap - 8'd1;

  typedef enum logic [1:0] {StHold, StSend, StGap, StDone} state_e;

  state_e            state_q;
  logic [19:0]       delay_q;
  logic [IdxW-1:0]   idx_q;
  logic [7:0]        gap_q;
  logic [7:0]        sent_q;
  logic [7:0]        frame_cnt_q;
  logic              busy_q;
  logic              tvalid_q;
  logic              tlast_q;
  logic [31:0]       tdata_q;

  logic              xfer;
  logic              hold_done;
  logic              gap_done;
  logic              finish;
  logic [7:0]        sent_inc;
  logic [31:0]       word0;

  assign xfer      = tvalid_q & axis.input_r_TREADY_0;
  assign hold_done = (Start_Delay_Value == 20'd0) || (delay_q == DelayLast);
  assign gap_done  = (gap_q == GapLast);
  // Sent-frames count saturates so Num_Frames comparison never aliases after a wrap.
  assign sent_inc  = (sent_q == 8'hFF) ? sent_q : sent_q + 8'd1;
  assign finish    = (Num_Frames != 8'd0) && (sent_inc == Num_Frames);

`ifdef MATRIX_SRC_ERR_INJECT_EN
  logic err_pend_q;
  logic inj_word_q;
  logic inj_now;
  logic load0;

  assign inj_now = err_pend_q | inject_error;
  assign word0   = inj_now ? FILL_VALUE + 32'd1 : FILL_VALUE;
  assign load0   = ((state_q == StHold) && hold_done) ||
                   ((state_q == StGap) && gap_done) ||
                   ((state_q == StSend) && xfer && tlast_q && !finish && (Frame_Gap == 8'd0));

  // Flag stays armed until the corrupted word 0 is actually accepted downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pend_q <= 1'b0;
      inj_word_q <= 1'b0;
    end else if (load0) begin
      err_pend_q <= inj_now;
      inj_word_q <= inj_now;
    end else if (xfer && inj_word_q) begin
      err_pend_q <= inject_error;
      inj_word_q <= 1'b0;
    end else if (inject_error) begin
      err_pend_q <= 1'b1;
    end
  end
`else
  assign word0 = FILL_VALUE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHold;
      delay_q     <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      sent_q      <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
    end else begin
      unique case (state_q)
        StHold: begin
          delay_q <= delay_q + 20'd1;
          if (hold_done) begin
            state_q  <= StSend;
            busy_q   <= 1'b1;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= word0;
          end
        end
        StSend: begin
          if (xfer) begin
            if (tlast_q) begin
              idx_q       <= '0;
              frame_cnt_q <= frame_cnt_q + 8'd1;
              sent_q      <= sent_inc;
              tlast_q     <= 1'b0;
              if (finish) begin
                state_q  <= StDone;
                busy_q   <= 1'b0;
                tvalid_q <= 1'b0;
              end else if (Frame_Gap == 8'd0) begin
                tdata_q <= word0;
              end else begin
                state_q  <= StGap;
                gap_q    <= '0;
                tvalid_q <= 1'b0;
              end
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              tdata_q <= FILL_VALUE;
              tlast_q <= ((idx_q + IdxW'(1)) == LastIdx);
            end
          end
        end
        StGap: begin
          if (gap_done) begin
            state_q  <= StSend;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= word0;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        StDone: begin
          busy_q   <= 1'b0;
          tvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign axis.input_r_TDATA_0  = tdata_q;
  assign axis.input_r_TVALID_0 = tvalid_q;
  assign axis.input_r_TLAST_0  = tlast_q;
  assign Frame_Counter         = frame_cnt_q;
  assign Busy                  = busy_q;

endmodule

// File: tb/tb_matrix_stream_source.sv
// Directed bench for matrix_stream_source: three instances cover single-frame, gapped multi-frame
// and back-to-back endless configurations; MATRIX_SRC_ERR_INJECT_EN enables the injection test.
module tb_matrix_stream_source;

  logic        clk = 1'b0;
  logic [2:0]  rst_vec = 3'b111;
  logic [1:0]  sel = 2'd0;
  logic        tready_drv = 1'b0;
  logic        inj_b = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  matrix_stream_source_if if_a ();
  matrix_stream_source_if if_b ();
  matrix_stream_source_if if_c ();
  logic [7:0] fc_a, fc_b, fc_c;
  logic       busy_a, busy_b, busy_c;

  assign if_a.input_r_TREADY_0 = (sel == 2'd0) & tready_drv;
  assign if_b.input_r_TREADY_0 = (sel == 2'd1) & tready_drv;
  assign if_c.input_r_TREADY_0 = (sel == 2'd2) & tready_drv;

  matrix_stream_source #(.Start_Delay_Value(20'd10), .Frame_Gap(8'd16), .Num_Frames(8'd1)) u_a (
    .clk(clk), .reset(rst_vec[0]),
`ifdef MATRIX_SRC_ERR_INJECT_EN
    .inject_error(1'b0),
`endif
    .axis(if_a.master), .Frame_Counter(fc_a), .Busy(busy_a)
  );

  matrix_stream_source #(.Start_Delay_Value(20'd5), .Frame_Gap(8'd4), .Num_Frames(8'd3)) u_b (
    .clk(clk), .reset(rst_vec[1]),
`ifdef MATRIX_SRC_ERR_INJECT_EN
    .inject_error(inj_b),
`endif
    .axis(if_b.master), .Frame_Counter(fc_b), .Busy(busy_b)
  );

  matrix_stream_source #(.Start_Delay_Value(20'd0), .Frame_Gap(8'd0), .Num_Frames(8'd0)) u_c (
    .clk(clk), .reset(rst_vec[2]),
`ifdef MATRIX_SRC_ERR_INJECT_EN
    .inject_error(1'b0),
`endif
    .axis(if_c.master), .Frame_Counter(fc_c), .Busy(busy_c)
  );

  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, m_busy;
  logic [7:0]  m_fc;

  always_comb begin
    m_tdata = if_a.input_r_TDATA_0; m_tvalid = if_a.input_r_TVALID_0;
    m_tlast = if_a.input_r_TLAST_0; m_fc = fc_a; m_busy = busy_a;
    if (sel == 2'd1) begin
      m_tdata = if_b.input_r_TDATA_0; m_tvalid = if_b.input_r_TVALID_0;
      m_tlast = if_b.input_r_TLAST_0; m_fc = fc_b; m_busy = busy_b;
    end else if (sel == 2'd2) begin
      m_tdata = if_c.input_r_TDATA_0; m_tvalid = if_c.input_r_TVALID_0;
      m_tlast = if_c.input_r_TLAST_0; m_fc = fc_c; m_busy = busy_c;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reset_dut(input int w);
    rst_vec[w] = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Called at a negedge just after reset release; returns the cycle number of first TVALID.
  task automatic wait_valid(output int cyc);
    int n = 0;
    while (!m_tvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    cyc = n + 1;
  endtask

  // Called at a negedge; returns at the negedge whose following edge accepts the TLAST word.
  task automatic collect_frame(input bit toggle, output int words, output int last_at,
                               output int bad, output int unstable, output logic [31:0] w0);
    logic        pend, pl;
    logic [31:0] pd;
    bit          done;
    words = 0; last_at = 0; bad = 0; unstable = 0; w0 = '0;
    pend = 1'b0; pl = 1'b0; pd = '0; done = 0;
    for (int c = 0; c < 600; c++) begin
      tready_drv = toggle ? c[0] : 1'b1;
      if (pend && (!m_tvalid || m_tdata != pd || m_tlast != pl)) unstable++;
      if (words > 0 && !m_tvalid) unstable++;
      pend = m_tvalid && !tready_drv;
      pd = m_tdata;
      pl = m_tlast;
      if (m_tvalid && tready_drv) begin
        words++;
        if (words == 1) w0 = m_tdata;
        else if (m_tdata != 32'd2) bad++;
        if (m_tlast) begin
          last_at = words;
          done = 1;
        end
      end
      if (done) break;
      @(negedge clk);
    end
  endtask

  task automatic count_idle(output int n, output int busy_low);
    n = 0;
    busy_low = 0;
    @(negedge clk);
    while (!m_tvalid && n < 100) begin
      n++;
      if (!m_busy) busy_low++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input bit toggle, input logic [31:0] exp_w0);
    int words, last_at, bad, unstable;
    logic [31:0] w0;
    collect_frame(toggle, words, last_at, bad, unstable, w0);
    check_eq({tag, "_words"}, words, 18);
    check_eq({tag, "_tlast_pos"}, last_at, 18);
    check_eq({tag, "_data_bad"}, bad, 0);
    check_eq({tag, "_unstable"}, unstable, 0);
    check_eq({tag, "_word0"}, w0, exp_w0);
  endtask

  initial begin
    int cyc, idle, blow, drops, tl_err, bad, fc1, fc255, hi;
    @(negedge clk);

    // T1: reset state, hold-off of 10, one frame then DONE
    sel = 2'd0; tready_drv = 1'b1;
    reset_dut(0);
    check_eq("rst_tvalid", m_tvalid, 0);
    check_eq("rst_tlast", m_tlast, 0);
    check_eq("rst_tdata", m_tdata, 0);
    check_eq("rst_fc", m_fc, 0);
    check_eq("rst_busy", m_busy, 0);
    rst_vec[0] = 1'b0;
    wait_valid(cyc);
    check_eq("t1_first_valid_cycle", cyc, 11);
    check_eq("t1_busy_send", m_busy, 1);
    check_frame("t1", 1'b0, 32'd2);
    @(negedge clk);
    check_eq("t1_fc", m_fc, 1);
    check_eq("t1_tvalid_done", m_tvalid, 0);
    check_eq("t1_busy_done", m_busy, 0);
    hi = 0;
    repeat (30) begin @(negedge clk); if (m_tvalid) hi++; end
    check_eq("t1_done_quiet", hi, 0);

    // T2: TREADY toggling every cycle
    reset_dut(0);
    rst_vec[0] = 1'b0;
    check_frame("t2", 1'b1, 32'd2);
    @(negedge clk);
    check_eq("t2_fc", m_fc, 1);

    // T5: reset while word 7 is presented, then full restart
    reset_dut(0);
    rst_vec[0] = 1'b0;
    tready_drv = 1'b1;
    wait_valid(cyc);
    repeat (7) @(negedge clk);
    check_eq("t5_mid_tvalid", m_tvalid, 1);
    rst_vec[0] = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_tvalid", m_tvalid, 0);
    check_eq("t5_rst_tdata", m_tdata, 0);
    check_eq("t5_rst_busy", m_busy, 0);
    check_eq("t5_rst_fc", m_fc, 0);
    rst_vec[0] = 1'b0;
    wait_valid(cyc);
    check_eq("t5_first_valid_cycle", cyc, 11);
    check_frame("t5", 1'b0, 32'd2);

    // T3 (+T6): three frames with 4-cycle gaps
    sel = 2'd1;
    reset_dut(1);
    rst_vec[1] = 1'b0;
    check_frame("t3_f1", 1'b0, 32'd2);
`ifdef MATRIX_SRC_ERR_INJECT_EN
    @(negedge clk);
    check_eq("t6_gap_tvalid", m_tvalid, 0);
    inj_b = 1'b1;
    @(negedge clk);
    inj_b = 1'b0;
    while (!m_tvalid) @(negedge clk);
    check_frame("t6_f2", 1'b0, 32'd3);
`else
    count_idle(idle, blow);
    check_eq("t3_gap1", idle, 4);
    check_eq("t3_gap1_busy_low", blow, 0);
    check_frame("t3_f2", 1'b0, 32'd2);
`endif
    count_idle(idle, blow);
    check_eq("t3_gap2", idle, 4);
    check_frame("t3_f3", 1'b0, 32'd2);
    @(negedge clk);
    check_eq("t3_fc", m_fc, 3);
    check_eq("t3_busy_after", m_busy, 0);
    hi = 0;
    repeat (30) begin @(negedge clk); if (m_tvalid) hi++; end
    check_eq("t3_no_fourth", hi, 0);

    // T4: zero hold-off, back-to-back, endless; Frame_Counter wraps
    sel = 2'd2; tready_drv = 1'b1;
    reset_dut(2);
    rst_vec[2] = 1'b0;
    wait_valid(cyc);
    check_eq("t4_first_valid_cycle", cyc, 2);
    drops = 0; tl_err = 0; bad = 0; fc1 = 0; fc255 = 0;
    for (int i = 0; i < 256 * 18; i++) begin
      if (!m_tvalid || !m_busy) drops++;
      if (m_tlast != ((i % 18) == 17)) tl_err++;
      if (m_tdata != 32'd2) bad++;
      @(negedge clk);
      if (i == 17) fc1 = m_fc;
      if (i == 255 * 18 - 1) fc255 = m_fc;
    end
    check_eq("t4_drops", drops, 0);
    check_eq("t4_tlast_err", tl_err, 0);
    check_eq("t4_data_bad", bad, 0);
    check_eq("t4_fc_first", fc1, 1);
    check_eq("t4_fc_255", fc255, 255);
    check_eq("t4_fc_wrap", m_fc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
